// File: rtl/rr_sel_sequencer_pkg.sv
// Shared types and constants for the round-robin select sequencer.
package sel_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } seq_state_t;

    // sel resets to the last channel so the first scan after reset starts at channel 0
    localparam logic [SEL_W-1:0] SEL_RST = 2'b11;

    // One-hot mask of a channel index, used to isolate "other" requesters
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        logic [NUM_CH-1:0] m;
        m     = '0;
        m[ch] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rr_sel_sequencer_if.sv
// Request/select bundle between the requesters and the sequencer.
interface rr_sel_sequencer_if;
    import sel_seq_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic              switch;

    // requester side: raises requests, watches the select
    modport master (output req, input sel, input valid, input switch);
    // sequencer side
    modport slave  (input req, output sel, output valid, output switch);

endinterface

// File: rtl/rr_sel_sequencer_pick4.sv
// Wrap-around first-set scan over four requests starting at channel `start`.
module rr_pick4
    import sel_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    // Scan start, start+1, ... modulo 4; the first set bit wins
    always_comb begin
        idx   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[start + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = start + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_sel_sequencer.sv
// Round-robin channel sequencer driving the mux select / decoder code.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no channel granted; valid low, sel keeps its last value
//   GRANT | channel sel owns the path; hold_cnt counts consecutive cycles
module rr_sel_sequencer
    import sel_seq_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    rr_sel_sequencer_if.slave   bus
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    seq_state_t       state, state_nx;
    logic [SEL_W-1:0] sel_q, sel_nx;
    logic [3:0]       hold_cnt, hold_nx;
    logic             switch_q, switch_nx;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             others_req;

    // Scan starts one past the current channel, so the current one is tried last
    rr_pick4 u_pick (
        .req   (bus.req),
        .start (sel_q + 2'd1),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign others_req = |(bus.req & ~ch_onehot(sel_q));

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= SEL_RST;
            hold_cnt <= 4'd0;
            switch_q <= 1'b0;
        end else begin
            state    <= state_nx;
            sel_q    <= sel_nx;
            hold_cnt <= hold_nx;
            switch_q <= switch_nx;
        end
    end

    // Next-state: grant, release, forced rotation, or hold with saturating count
    always_comb begin
        state_nx  = state;
        sel_nx    = sel_q;
        hold_nx   = hold_cnt;
        switch_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx  = GRANT;
                    sel_nx    = pick_idx;
                    switch_nx = 1'b1;
                    hold_nx   = 4'd1;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    if (pick_found) begin
                        // owner released while others wait: hand over with no valid gap
                        sel_nx    = pick_idx;
                        switch_nx = 1'b1;
                        hold_nx   = 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (hold_cnt == HOLD_MAX && others_req) begin
                    // pick cannot return sel_q here because another bit is set earlier in the scan
                    sel_nx    = pick_idx;
                    switch_nx = 1'b1;
                    hold_nx   = 4'd1;
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_nx = hold_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.sel    = sel_q;
    assign bus.valid  = (state == GRANT);
    assign bus.switch = switch_q;

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Directed bench for rr_sel_sequencer with hand-computed expectations.
module tb_rr_sel_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   sw_count;

    rr_sel_sequencer_if bus ();

    rr_sel_sequencer #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] es, input logic ev, input logic esw);
        checks++;
        assert (bus.sel === es) else begin
            errors++;
            $error("FAIL %s sel observed %0d expected %0d", tag, bus.sel, es);
        end
        checks++;
        assert (bus.valid === ev) else begin
            errors++;
            $error("FAIL %s valid observed %0b expected %0b", tag, bus.valid, ev);
        end
        checks++;
        assert (bus.switch === esw) else begin
            errors++;
            $error("FAIL %s switch observed %0b expected %0b", tag, bus.switch, esw);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset", 2'd3, 1'b0, 1'b0);

        // idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_noreq", 2'd3, 1'b0, 1'b0);
        end

        // all channels requesting: rotate every MAX_HOLD cycles
        bus.req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("all_req_rotate", 2'(i / 4), 1'b1, (i % 4) == 0);
        end

        // lone requester keeps grant with saturated counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("reset2", 2'd3, 1'b0, 1'b0);
        bus.req  = 4'b0100;
        sw_count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lone_hold", 2'd2, 1'b1, i == 0);
            if (bus.switch === 1'b1) sw_count++;
        end
        checks++;
        assert (sw_count == 1) else begin
            errors++;
            $error("FAIL lone_switch_count observed %0d expected 1", sw_count);
        end

        // hand over to channel 1, then release into 0 and 3 in one step
        bus.req = 4'b0010;
        tick();
        chk("handover_to1", 2'd1, 1'b1, 1'b1);
        // glitch between edges is ignored
        bus.req = 4'b1000;
        #3;
        bus.req = 4'b0010;
        tick();
        chk("midcycle_glitch", 2'd1, 1'b1, 1'b0);
        bus.req = 4'b1001;
        tick();
        chk("release_to3", 2'd3, 1'b1, 1'b1);

        // move to channel 2, then drop everything
        bus.req = 4'b0100;
        tick();
        chk("handover_to2", 2'd2, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk("drop_to_idle", 2'd2, 1'b0, 1'b0);
        bus.req = 4'b0101;
        tick();
        chk("regrant_from2", 2'd0, 1'b1, 1'b1);

        // reset in the middle of a grant
        bus.req = 4'b0010;
        tick();
        chk("grant1", 2'd1, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("reset_midgrant", 2'd3, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("grant_after_reset", 2'd1, 1'b1, 1'b1);
        tick();
        chk("grant_after_reset_hold", 2'd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
